// File: rtl/lfsr_checker_if.sv
// rtl/lfsr_checker_if.sv - received-word stream bundle for the LFSR checker
//
// Purpose: carries one received LFSR word per cycle from a source to the
//   checker.
// Signals:
//   data_valid  1   data holds a new LFSR word this cycle
//   data        16  received word
// Modports: master drives the stream, slave (the checker) samples it.

interface lfsr_checker_if;
  logic        data_valid;
  logic [15:0] data;

  modport master (output data_valid, output data);
  modport slave  (input  data_valid, input  data);
endinterface

// File: rtl/lfsr_checker.sv
// rtl/lfsr_checker.sv - self-synchronising 16-bit Fibonacci LFSR stream checker
//
// Purpose: locks onto an incoming LFSR word stream, then predicts each next
//   word and flags and counts mismatches while locked.
// Optional feature macro: LFSR_CHECKER_BIT_ERR_EN (enables the errored-bit
//   counter; when undefined, o_bit_err_count is tied to 0).
// Ports:
//   i_clk            in   1      clock, all logic on posedge
//   i_rst_n          in   1      synchronous active-low reset
//   s_in             slave       data_valid / data word stream
//   i_clr_counts     in   1      synchronous clear of the three counters
//   o_locked         out  1      checker is in LOCKED
//   o_error          out  1      1-cycle pulse on a locked mismatch
//   o_lost_lock      out  1      1-cycle pulse on LOCKED -> SEARCH
//   o_err_count      out  ERR_W  mismatched words while locked (saturating)
//   o_word_count     out  ERR_W  words checked while locked (saturating)
//   o_bit_err_count  out  ERR_W  errored bits while locked (saturating)

module lfsr_checker #(
  parameter logic [15:0] TAPS          = 16'hB400,
  parameter int          LOCK_COUNT    = 4,
  parameter int          UNLOCK_MISSES = 8,
  parameter int          ERR_W         = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  lfsr_checker_if.slave    s_in,
  input  logic             i_clr_counts,
  output logic             o_locked,
  output logic             o_error,
  output logic             o_lost_lock,
  output logic [ERR_W-1:0] o_err_count,
  output logic [ERR_W-1:0] o_word_count,
  output logic [ERR_W-1:0] o_bit_err_count
);

  localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam int MISS_W  = $clog2(UNLOCK_MISSES + 1);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  function automatic logic [15:0] f_next(input logic [15:0] x);
    return {x[14:0], ^(x & TAPS)};
  endfunction

  state_t             r_state;
  logic [15:0]        r_ref;
  logic [MATCH_W-1:0] r_match;
  logic [MISS_W-1:0]  r_miss;
  logic               r_locked;
  logic               r_error;
  logic               r_lost_lock;
  logic [ERR_W-1:0]   r_err_count;
  logic [ERR_W-1:0]   r_word_count;

  logic [15:0]        w_pred;
  logic               w_hit;
  logic               w_zero;
  logic [MATCH_W-1:0] w_match_nxt;
  logic [MISS_W-1:0]  w_miss_nxt;
  logic [ERR_W-1:0]   w_err_inc;
  logic [ERR_W-1:0]   w_word_inc;

  assign w_pred      = f_next(r_ref);
  assign w_hit       = (s_in.data == w_pred);
  assign w_zero      = (s_in.data == 16'h0000);
  assign w_match_nxt = r_match + MATCH_W'(1);
  assign w_miss_nxt  = r_miss + MISS_W'(1);
  // Saturating increments: hold at all-ones instead of wrapping.
  assign w_err_inc   = (&r_err_count)  ? r_err_count  : r_err_count + ERR_W'(1);
  assign w_word_inc  = (&r_word_count) ? r_word_count : r_word_count + ERR_W'(1);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= ST_SEARCH;
      r_ref        <= '0;
      r_match      <= '0;
      r_miss       <= '0;
      r_locked     <= 1'b0;
      r_error      <= 1'b0;
      r_lost_lock  <= 1'b0;
      r_err_count  <= '0;
      r_word_count <= '0;
    end else begin
      r_error     <= 1'b0;
      r_lost_lock <= 1'b0;
      if (s_in.data_valid) begin
        case (r_state)
          ST_SEARCH: begin
            // All-zero is the LFSR lockup word and can never seed a valid run.
            if (!w_zero) begin
              r_ref   <= s_in.data;
              r_match <= '0;
              r_state <= ST_VERIFY;
            end
          end
          ST_VERIFY: begin
            if (w_hit) begin
              r_ref   <= s_in.data;
              r_match <= w_match_nxt;
              if (w_match_nxt == MATCH_W'(LOCK_COUNT)) begin
                r_state  <= ST_LOCKED;
                r_locked <= 1'b1;
                r_miss   <= '0;
              end
            end else if (!w_zero) begin
              r_ref   <= s_in.data;
              r_match <= '0;
            end else begin
              r_state <= ST_SEARCH;
            end
          end
          ST_LOCKED: begin
            // Flywheel: the prediction advances from itself, so a corrupted
            // word never disturbs the reference.
            r_ref        <= w_pred;
            r_word_count <= w_word_inc;
            if (w_hit) begin
              r_miss <= '0;
            end else begin
              r_error     <= 1'b1;
              r_err_count <= w_err_inc;
              r_miss      <= w_miss_nxt;
              if (w_miss_nxt == MISS_W'(UNLOCK_MISSES)) begin
                r_state     <= ST_SEARCH;
                r_locked    <= 1'b0;
                r_lost_lock <= 1'b1;
              end
            end
          end
          default: begin
            r_state  <= ST_SEARCH;
            r_locked <= 1'b0;
          end
        endcase
      end
      // Clear wins over a coincident increment; pulses are unaffected.
      if (i_clr_counts) begin
        r_err_count  <= '0;
        r_word_count <= '0;
      end
    end
  end

`ifdef LFSR_CHECKER_BIT_ERR_EN
  logic [15:0]      w_diff;
  logic [4:0]       w_pop;
  logic [ERR_W:0]   w_bit_sum;
  logic [ERR_W-1:0] w_bit_sat;
  logic [ERR_W-1:0] r_bit_err_count;

  assign w_diff = s_in.data ^ w_pred;

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < 16; i++) begin
      w_pop = w_pop + 5'(w_diff[i]);
    end
  end

  // One extra bit catches overflow so the sum can clamp to all-ones.
  assign w_bit_sum = {1'b0, r_bit_err_count} + (ERR_W + 1)'(w_pop);
  assign w_bit_sat = w_bit_sum[ERR_W] ? '1 : w_bit_sum[ERR_W-1:0];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_bit_err_count <= '0;
    end else if (i_clr_counts) begin
      r_bit_err_count <= '0;
    end else if (s_in.data_valid && (r_state == ST_LOCKED) && !w_hit) begin
      r_bit_err_count <= w_bit_sat;
    end
  end

  assign o_bit_err_count = r_bit_err_count;
`else
  assign o_bit_err_count = '0;
`endif

  assign o_locked     = r_locked;
  assign o_error      = r_error;
  assign o_lost_lock  = r_lost_lock;
  assign o_err_count  = r_err_count;
  assign o_word_count = r_word_count;

endmodule

// File: tb/tb_lfsr_checker.sv
// tb/tb_lfsr_checker.sv - directed plus randomized bench for lfsr_checker

module tb_lfsr_checker;

  localparam int W     = 6;
  localparam int MAXC  = (1 << W) - 1;
  localparam int LOCKN = 4;
  localparam int MISSN = 8;

  logic         clk;
  logic         rst_n;
  logic         clr;
  logic         locked, error, lost_lock;
  logic [W-1:0] err_count, word_count, bit_err_count;

  lfsr_checker_if u_if ();

  lfsr_checker #(
    .TAPS          (16'hB400),
    .LOCK_COUNT    (LOCKN),
    .UNLOCK_MISSES (MISSN),
    .ERR_W         (W)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .s_in            (u_if),
    .i_clr_counts    (clr),
    .o_locked        (locked),
    .o_error         (error),
    .o_lost_lock     (lost_lock),
    .o_err_count     (err_count),
    .o_word_count    (word_count),
    .o_bit_err_count (bit_err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: phase 0 = searching, 1 = verifying, 2 = locked.
  int          m_phase;
  logic [15:0] m_last;
  int          m_good_run;
  int          m_bad_run;
  int          m_err, m_words, m_bits;
  bit          m_error, m_lost;
  logic [15:0] g;

  function automatic logic [15:0] lfsr_step(input logic [15:0] x);
    int v, fb;
    v  = int'(x);
    fb = ((v >> 15) ^ (v >> 13) ^ (v >> 12) ^ (v >> 10)) & 1;
    return 16'(((v << 1) & 32'hFFFF) | fb);
  endfunction

  function automatic int sat(input int v);
    return (v > MAXC) ? MAXC : v;
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".locked"},    int'(locked),        (m_phase == 2) ? 1 : 0);
    check({tag, ".error"},     int'(error),         int'(m_error));
    check({tag, ".lost_lock"}, int'(lost_lock),     int'(m_lost));
    check({tag, ".err_cnt"},   int'(err_count),     m_err);
    check({tag, ".word_cnt"},  int'(word_count),    m_words);
    check({tag, ".bit_cnt"},   int'(bit_err_count), m_bits);
  endtask

  task automatic model_reset();
    m_phase = 0; m_last = '0; m_good_run = 0; m_bad_run = 0;
    m_err = 0; m_words = 0; m_bits = 0; m_error = 0; m_lost = 0;
  endtask

  task automatic model_word(input bit v, input logic [15:0] d, input bit c);
    logic [15:0] p;
    m_error = 0;
    m_lost  = 0;
    if (v) begin
      p = lfsr_step(m_last);
      if (m_phase == 0) begin
        if (d != 0) begin m_last = d; m_good_run = 0; m_phase = 1; end
      end else if (m_phase == 1) begin
        if (d == p) begin
          m_last = d;
          m_good_run++;
          if (m_good_run == LOCKN) begin m_phase = 2; m_bad_run = 0; end
        end else if (d != 0) begin
          m_last = d; m_good_run = 0;
        end else begin
          m_phase = 0;
        end
      end else begin
        m_last  = p;
        m_words = sat(m_words + 1);
        if (d == p) begin
          m_bad_run = 0;
        end else begin
          m_error = 1;
          m_err   = sat(m_err + 1);
`ifdef LFSR_CHECKER_BIT_ERR_EN
          m_bits  = sat(m_bits + $countones(d ^ p));
`endif
          m_bad_run++;
          if (m_bad_run == MISSN) begin m_phase = 0; m_lost = 1; end
        end
      end
    end
    if (c) begin m_err = 0; m_words = 0; m_bits = 0; end
  endtask

  task automatic send(input bit v, input logic [15:0] d, input bit c, input string tag);
    u_if.data_valid = v;
    u_if.data       = d;
    clr             = c;
    @(posedge clk);
    #1;
    model_word(v, d, c);
    check_all(tag);
    u_if.data_valid = 1'b0;
    clr             = 1'b0;
  endtask

  task automatic send_good(input string tag);
    g = lfsr_step(g);
    send(1'b1, g, 1'b0, tag);
  endtask

  initial begin
    int n, r, len;
    int e0;
    rst_n = 1'b0; clr = 1'b0; u_if.data_valid = 1'b0; u_if.data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1'b1;

    // Lock on the reference sequence; locked rises with the 5th word.
    g = 16'hACE1;
    send(1'b1, g, 1'b0, "seed");
    for (int i = 0; i < 3; i++) send_good("verify");
    check("not_locked_4th", int'(locked), 0);
    send_good("lock5");
    check("locked_5th", int'(locked), 1);
    for (int i = 0; i < 10; i++) send_good("run");

    // Single flipped bit: one pulse, flywheel keeps tracking.
    g = lfsr_step(g);
    send(1'b1, g ^ 16'h0001, 1'b0, "bad1");
    check("bad1_err", int'(error), 1);
    for (int i = 0; i < 5; i++) send_good("after_bad");
    check("still_locked", int'(locked), 1);
    for (int i = 0; i < 3; i++) send(1'b0, 16'h1234, 1'b0, "idle");

    // Byte-wide corruption.
    n = int'(bit_err_count);
    g = lfsr_step(g);
    send(1'b1, g ^ 16'h00FF, 1'b0, "bad8");
`ifdef LFSR_CHECKER_BIT_ERR_EN
    check("bit_err_plus8", int'(bit_err_count), sat(n + 8));
`else
    check("bit_err_tied", int'(bit_err_count), 0);
`endif
    send_good("recover");

    // Eight zero words drop lock on the eighth.
    e0 = int'(err_count);
    for (int i = 0; i < MISSN; i++) begin
      g = lfsr_step(g);
      send(1'b1, 16'h0000, 1'b0, "zeros");
      if (i == MISSN - 2) check("no_lost_yet", int'(lost_lock), 0);
    end
    check("lost_pulse", int'(lost_lock), 1);
    check("unlocked", int'(locked), 0);
    check("err_plus8", int'(err_count), sat(e0 + 8));

    // Zeros ignored in search, then relock from ACE1.
    send(1'b1, 16'h0000, 1'b0, "z_ign0");
    send(1'b1, 16'h0000, 1'b0, "z_ign1");
    g = 16'hACE1;
    send(1'b1, g, 1'b0, "reseed");
    for (int i = 0; i < LOCKN; i++) send_good("relock");
    check("relocked", int'(locked), 1);

    // Clear, build err_count=3, then clear coincident with a bad word.
    g = lfsr_step(g);
    send(1'b1, g, 1'b1, "clr_good");
    for (int i = 0; i < 3; i++) begin
      g = lfsr_step(g);
      send(1'b1, g ^ 16'h8000, 1'b0, "bad3");
    end
    check("err_is3", int'(err_count), 3);
    g = lfsr_step(g);
    send(1'b1, g ^ 16'h0100, 1'b1, "clr_bad");
    check("clr_err_zero", int'(err_count), 0);
    check("clr_err_pulse", int'(error), 1);

    // Saturation of the word counter.
    for (int i = 0; i < MAXC + 6; i++) send_good("sat");
    check("word_sat", int'(word_count), MAXC);

    // Randomized traffic: good words, corruptions, zero bursts, idles, clears.
    for (int i = 0; i < 500; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 10) begin
        send(1'b0, 16'($urandom), 1'b0, "rnd_idle");
      end else if (r < 22) begin
        g = lfsr_step(g);
        send(1'b1, g ^ 16'($urandom_range(1, 16'hFFFF)), 1'b0, "rnd_bad");
      end else if (r < 26) begin
        len = int'($urandom_range(1, 10));
        for (int k = 0; k < len; k++) begin
          g = lfsr_step(g);
          send(1'b1, 16'h0000, 1'b0, "rnd_zero");
        end
      end else if (r < 28) begin
        g = lfsr_step(g);
        send(1'b1, g, 1'b1, "rnd_clr");
      end else begin
        send_good("rnd_good");
      end
    end

    // Reset while locked.
    n = 0;
    while (!locked && n < 20) begin
      send_good("prelock");
      n++;
    end
    check("locked_before_rst", int'(locked), 1);
    rst_n = 1'b0;
    g = lfsr_step(g);
    u_if.data_valid = 1'b1;
    u_if.data       = g;
    @(posedge clk);
    #1;
    model_reset();
    check_all("mid_reset");
    rst_n = 1'b1;
    send_good("post_reset");
    check("post_reset_unlocked", int'(locked), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
